// File: rtl/puzzle_lock_core.sv
// puzzle_lock_core: sequential combination lock with a programmable secret,
// limited attempts and a timed lockout. Digits are checked in order against
// the stored secret; while unlocked, a new secret can be written through a
// shadow buffer that is only committed once every digit has been supplied.
module puzzle_lock_core #(
  parameter int CODE_W         = 4,
  parameter int DEPTH          = 4,
  parameter int MAX_TRIES      = 3,
  parameter int LOCKOUT_CYCLES = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [CODE_W-1:0]            code_in,
  input  logic                         code_valid,
  input  logic                         clear,
  input  logic                         prog_en,
  output logic                         unlocked,
  output logic                         locked_out,
  output logic                         fail_pulse,
  output logic [$clog2(DEPTH+1)-1:0]   progress,
  output logic [3:0]                   tries_left
);

  localparam int PW = $clog2(DEPTH + 1);
  localparam int IW = $clog2(DEPTH);
  localparam logic [PW-1:0] LAST_IDX   = PW'(DEPTH - 1);
  localparam logic [3:0]    TRIES_INIT = 4'(MAX_TRIES);
  localparam logic [15:0]   LOCK_INIT  = 16'(LOCKOUT_CYCLES);

  typedef enum logic [1:0] {
    ST_ENTRY   = 2'd0,
    ST_OPEN    = 2'd1,
    ST_PROG    = 2'd2,
    ST_LOCKOUT = 2'd3
  } state_t;

  // Factory secret: digit i holds (i+1) truncated to the digit width.
  function automatic logic [CODE_W-1:0] default_digit(input int i);
    return CODE_W'(i + 1);
  endfunction

  state_t            state_r;
  logic [15:0]       lock_cnt_r;
  logic [CODE_W-1:0] secret_r [DEPTH];
  logic [CODE_W-1:0] shadow_r [DEPTH];
  logic [IW-1:0]     idx_s;
  logic              digit_ok_s;

  // progress never exceeds DEPTH-1, so its low bits address the digit arrays.
  assign idx_s      = progress[IW-1:0];
  assign digit_ok_s = (code_in == secret_r[idx_s]);

  // Lock state machine: state, secret storage and all registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= ST_ENTRY;
      lock_cnt_r <= 16'd0;
      unlocked   <= 1'b0;
      locked_out <= 1'b0;
      fail_pulse <= 1'b0;
      progress   <= {PW{1'b0}};
      tries_left <= TRIES_INIT;
      for (int i = 0; i < DEPTH; i++) begin
        secret_r[i] <= default_digit(i);
        shadow_r[i] <= {CODE_W{1'b0}};
      end
    end else begin
      fail_pulse <= 1'b0;
      case (state_r)
        ST_ENTRY: begin
          if (clear) begin
            progress <= {PW{1'b0}};
          end else if (code_valid) begin
            if (digit_ok_s) begin
              if (progress == LAST_IDX) begin
                state_r    <= ST_OPEN;
                unlocked   <= 1'b1;
                progress   <= {PW{1'b0}};
                tries_left <= TRIES_INIT;
              end else begin
                progress <= progress + PW'(1);
              end
            end else begin
              progress   <= {PW{1'b0}};
              fail_pulse <= 1'b1;
              if (tries_left == 4'd1) begin
                state_r    <= ST_LOCKOUT;
                locked_out <= 1'b1;
                lock_cnt_r <= LOCK_INIT;
                tries_left <= 4'd0;
              end else begin
                tries_left <= tries_left - 4'd1;
              end
            end
          end else begin
            progress <= progress;
          end
        end

        ST_OPEN: begin
          // Digits arriving while open are deliberately ignored.
          if (clear) begin
            state_r    <= ST_ENTRY;
            unlocked   <= 1'b0;
            progress   <= {PW{1'b0}};
            tries_left <= TRIES_INIT;
          end else if (prog_en) begin
            state_r  <= ST_PROG;
            progress <= {PW{1'b0}};
          end else begin
            state_r <= ST_OPEN;
          end
        end

        ST_PROG: begin
          if (!prog_en || clear) begin
            // Abort: shadow contents are simply never committed.
            state_r  <= ST_OPEN;
            progress <= {PW{1'b0}};
          end else if (code_valid) begin
            shadow_r[idx_s] <= code_in;
            if (progress == LAST_IDX) begin
              // Commit the full sequence, final digit taken straight from the input.
              for (int i = 0; i < DEPTH; i++) begin
                if (i == DEPTH - 1) begin
                  secret_r[i] <= code_in;
                end else begin
                  secret_r[i] <= shadow_r[i];
                end
              end
              state_r    <= ST_ENTRY;
              unlocked   <= 1'b0;
              progress   <= {PW{1'b0}};
              tries_left <= TRIES_INIT;
            end else begin
              progress <= progress + PW'(1);
            end
          end else begin
            state_r <= ST_PROG;
          end
        end

        ST_LOCKOUT: begin
          if (lock_cnt_r == 16'd1) begin
            state_r    <= ST_ENTRY;
            locked_out <= 1'b0;
            lock_cnt_r <= 16'd0;
            progress   <= {PW{1'b0}};
            tries_left <= TRIES_INIT;
          end else begin
            lock_cnt_r <= lock_cnt_r - 16'd1;
          end
        end

        default: begin
          state_r    <= ST_ENTRY;
          unlocked   <= 1'b0;
          locked_out <= 1'b0;
          progress   <= {PW{1'b0}};
          tries_left <= TRIES_INIT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_puzzle_lock_core.sv
// Scoreboard bench for puzzle_lock_core: each driven cycle pushes the
// hand-derived expected outputs; a monitor pops and compares after each edge.
module tb_puzzle_lock_core;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] code_in;
  logic       code_valid;
  logic       clear;
  logic       prog_en;
  logic       unlocked;
  logic       locked_out;
  logic       fail_pulse;
  logic [2:0] progress;
  logic [3:0] tries_left;

  typedef struct packed {
    logic       u;
    logic       l;
    logic       f;
    logic [2:0] p;
    logic [3:0] t;
  } exp_t;

  exp_t exp_q [$];
  int   id_q  [$];
  int   checks   = 0;
  int   failures = 0;
  int   step_id  = 0;

  puzzle_lock_core #(
    .CODE_W(4), .DEPTH(4), .MAX_TRIES(3), .LOCKOUT_CYCLES(16)
  ) dut (
    .clk(clk), .rst(rst), .code_in(code_in), .code_valid(code_valid),
    .clear(clear), .prog_en(prog_en), .unlocked(unlocked),
    .locked_out(locked_out), .fail_pulse(fail_pulse),
    .progress(progress), .tries_left(tries_left)
  );

  always #5 clk = ~clk;

  // Monitor: after every rising edge, compare the DUT against the oldest expectation.
  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      exp_t e;
      exp_t a;
      int   id;
      e  = exp_q.pop_front();
      id = id_q.pop_front();
      a  = '{u: unlocked, l: locked_out, f: fail_pulse, p: progress, t: tries_left};
      checks++;
      if (a !== e) begin
        failures++;
        $display("FAIL step%0d: got unl=%0b lo=%0b fp=%0b prog=%0d tries=%0d, want unl=%0b lo=%0b fp=%0b prog=%0d tries=%0d",
                 id, a.u, a.l, a.f, a.p, a.t, e.u, e.l, e.f, e.p, e.t);
      end
    end
  end

  // Drive one cycle of inputs and queue the outputs expected after the next edge.
  task automatic step(input logic v, input logic [3:0] c, input logic clr, input logic pe,
                      input logic eu, input logic el, input logic ef,
                      input logic [2:0] ep, input logic [3:0] et);
    exp_t e;
    @(negedge clk);
    code_valid = v;
    code_in    = c;
    clear      = clr;
    prog_en    = pe;
    e = '{u: eu, l: el, f: ef, p: ep, t: et};
    step_id++;
    exp_q.push_back(e);
    id_q.push_back(step_id);
  endtask

  // Direct output check used where no clock edge is involved.
  task automatic check_now(input string name, input logic [9:0] act, input logic [9:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %b, want %b", name, act, req);
    end
  endtask

  // Enter digits a,b,c,d from ENTRY with full tries; last one opens the lock.
  task automatic unlock_seq(input logic [3:0] a, input logic [3:0] b,
                            input logic [3:0] c, input logic [3:0] d, input logic [3:0] t0);
    step(1'b1, a, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd1, t0);
    step(1'b1, b, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd2, t0);
    step(1'b1, c, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd3, t0);
    step(1'b1, d, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 4'd3);
  endtask

  task automatic do_clear();
    step(1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 4'd3);
  endtask

  initial begin
    rst = 1'b1; code_in = 4'd0; code_valid = 1'b0; clear = 1'b0; prog_en = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_now("reset_state", {unlocked, locked_out, fail_pulse, progress, tries_left},
              {1'b0, 1'b0, 1'b0, 3'd0, 4'd3});
    rst = 1'b0;

    // Default unlock 1,2,3,4, then relock.
    unlock_seq(4'd1, 4'd2, 4'd3, 4'd4, 4'd3);
    do_clear();

    // Wrong digit and recovery.
    step(1'b1, 4'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd1, 4'd3);
    step(1'b1, 4'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd2, 4'd3);
    step(1'b1, 4'd7, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 4'd2);
    step(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 4'd2);
    unlock_seq(4'd1, 4'd2, 4'd3, 4'd4, 4'd2);
    do_clear();

    // Clear in ENTRY drops partial progress with no penalty.
    step(1'b1, 4'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd1, 4'd3);
    step(1'b1, 4'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 4'd3);

    // Lockout: three wrong digits, 16 locked cycles with ignored entries.
    step(1'b1, 4'd9, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 4'd2);
    step(1'b1, 4'd9, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 4'd1);
    step(1'b1, 4'd9, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 3'd0, 4'd0);
    for (int k = 1; k < 16; k++) begin
      step(1'b1, 4'd1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 4'd0);
    end
    step(1'b1, 4'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 4'd3);
    step(1'b1, 4'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd1, 4'd3);
    do_clear();

    // Reprogram to 9,8,7,6.
    unlock_seq(4'd1, 4'd2, 4'd3, 4'd4, 4'd3);
    step(1'b1, 4'd5, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 4'd3);
    step(1'b0, 4'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 4'd3);
    step(1'b1, 4'd9, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 3'd1, 4'd3);
    step(1'b1, 4'd8, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 3'd2, 4'd3);
    step(1'b1, 4'd7, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 3'd3, 4'd3);
    step(1'b1, 4'd6, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 4'd3);
    step(1'b1, 4'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 4'd2);
    step(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 4'd2);
    unlock_seq(4'd9, 4'd8, 4'd7, 4'd6, 4'd2);
    do_clear();

    // Async reset in the middle of a lockout.
    step(1'b1, 4'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 4'd2);
    step(1'b1, 4'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 4'd1);
    step(1'b1, 4'd1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 3'd0, 4'd0);
    step(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 4'd0);
    step(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 4'd0);
    @(negedge clk);
    code_valid = 1'b0; clear = 1'b0; prog_en = 1'b0;
    #2;
    check_now("pre_async_reset", {unlocked, locked_out, fail_pulse, progress, tries_left},
              {1'b0, 1'b1, 1'b0, 3'd0, 4'd0});
    rst = 1'b1;
    #1;
    check_now("async_reset", {unlocked, locked_out, fail_pulse, progress, tries_left},
              {1'b0, 1'b0, 1'b0, 3'd0, 4'd3});
    @(negedge clk);
    rst = 1'b0;
    unlock_seq(4'd1, 4'd2, 4'd3, 4'd4, 4'd3);

    // Aborted programming keeps the old secret.
    step(1'b0, 4'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 4'd3);
    step(1'b1, 4'd5, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 3'd1, 4'd3);
    step(1'b1, 4'd5, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 3'd2, 4'd3);
    step(1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 4'd3);
    do_clear();
    unlock_seq(4'd1, 4'd2, 4'd3, 4'd4, 4'd3);
    do_clear();

    // Drain the scoreboard with a bounded wait.
    @(negedge clk);
    code_valid = 1'b0; clear = 1'b0; prog_en = 1'b0;
    for (int w = 0; w < 20 && exp_q.size() > 0; w++) begin
      @(negedge clk);
    end
    if (exp_q.size() > 0) begin
      failures++;
      $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
